// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction-speed game controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_WAIT_DELAY = 3'd2,
    S_LED_ON     = 3'd3,
    S_RESULT     = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Wide enough for any TIME_W the controller is built with; callers cast back.
  function automatic logic [31:0] min_time(input logic [31:0] a, input logic [31:0] b);
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr16.sv
// 16-bit Galois LFSR, free-running from the seed; exposes its low OUT_W bits.
module lfsr16
  import reaction_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  output logic [OUT_W-1:0] rnd
);

  logic [15:0] lfsr_q;

  // Right-shifting Galois form: a nonzero seed never reaches the all-zero state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (load) begin
      lfsr_q <= LFSR_SEED;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-player, multi-round reaction game: random wait, LED, tick-timed reaction,
// false-start and timeout detection, per-round winner and best time per game.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int ROUNDS    = 3,
  parameter int TIME_W    = 10,
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 500,
  parameter int RAND_W    = 10,
  parameter int TIMEOUT   = 1000,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] btn,
  output logic                 delay_flag,
  output logic                 led_flag,
  output logic                 rxn_flag,
  output logic                 result_valid,
  output logic [PW-1:0]        winner,
  output logic [TIME_W-1:0]    rxn_time,
  output logic                 no_winner,
  output logic                 timeout,
  output logic [N_PLAYERS-1:0] false_start,
  output logic [RW-1:0]        round_idx,
  output logic [TIME_W-1:0]    best_time,
  output logic                 game_done,
  output state_t               state_dbg
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int DLY_W = $clog2(MIN_DELAY + (1 << RAND_W));

  state_t               state, state_nxt;
  logic [PS_W-1:0]      presc;
  logic                 tick;
  logic [DLY_W-1:0]     delay_cnt;
  logic [TIME_W-1:0]    rxn_cnt;
  logic [RAND_W-1:0]    rnd;
  logic [N_PLAYERS-1:0] fs_nxt;
  logic [N_PLAYERS-1:0] elig;
  logic [PW-1:0]        first_idx;
  logic                 all_dq;
  logic                 press;
  logic                 to_hit;
  logic                 last_round;

  lfsr16 #(.OUT_W(RAND_W)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .load (1'b0),
    .rnd  (rnd)
  );

  assign tick      = (presc == PS_W'(TICK_DIV - 1));
  assign state_dbg = state;

  // Round decisions and the lowest-index priority encoder over eligible presses.
  always_comb begin
    fs_nxt     = false_start | btn;
    all_dq     = &fs_nxt;
    elig       = btn & ~false_start;
    press      = |elig;
    to_hit     = (rxn_cnt == TIME_W'(TIMEOUT));
    last_round = (round_idx == RW'(ROUNDS - 1));
    first_idx  = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (elig[i]) first_idx = PW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = S_ARM;
      S_ARM:        state_nxt = S_WAIT_DELAY;
      S_WAIT_DELAY: begin
        if (all_dq)                state_nxt = S_RESULT;
        else if (delay_cnt == '0)  state_nxt = S_LED_ON;
      end
      S_LED_ON:     if (press || to_hit) state_nxt = S_RESULT;
      S_RESULT:     state_nxt = last_round ? S_DONE : S_ARM;
      S_DONE:       if (start) state_nxt = S_ARM;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Flags are decoded from the next state so they change together with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_flag <= 1'b0;
      led_flag   <= 1'b0;
      rxn_flag   <= 1'b0;
      game_done  <= 1'b0;
    end else begin
      delay_flag <= (state_nxt == S_ARM) || (state_nxt == S_WAIT_DELAY);
      led_flag   <= (state_nxt == S_LED_ON);
      rxn_flag   <= (state_nxt == S_RESULT) || (state_nxt == S_DONE);
      game_done  <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc        <= '0;
      delay_cnt    <= '0;
      rxn_cnt      <= '0;
      result_valid <= 1'b0;
      winner       <= '0;
      rxn_time     <= '0;
      no_winner    <= 1'b0;
      timeout      <= 1'b0;
      false_start  <= '0;
      round_idx    <= '0;
      best_time    <= '1;
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            round_idx <= '0;
            best_time <= '1;
            winner    <= '0;
            rxn_time  <= '0;
            no_winner <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        S_ARM: begin
          delay_cnt   <= DLY_W'(MIN_DELAY) + DLY_W'(rnd);
          presc       <= '0;
          false_start <= '0;
          winner      <= '0;
          rxn_time    <= '0;
          no_winner   <= 1'b0;
          timeout     <= 1'b0;
        end
        S_WAIT_DELAY: begin
          false_start <= fs_nxt;
          if (all_dq) begin
            result_valid <= 1'b1;
            no_winner    <= 1'b1;
            timeout      <= 1'b0;
          end else if (delay_cnt == '0) begin
            rxn_cnt <= '0;
            presc   <= '0;
          end else if (tick) begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        S_LED_ON: begin
          // An eligible press takes priority over a timeout in the same cycle.
          if (press) begin
            result_valid <= 1'b1;
            winner       <= first_idx;
            rxn_time     <= rxn_cnt;
          end else if (to_hit) begin
            result_valid <= 1'b1;
            no_winner    <= 1'b1;
            timeout      <= 1'b1;
            rxn_time     <= TIME_W'(TIMEOUT);
          end else if (tick) begin
            rxn_cnt <= rxn_cnt + 1'b1;
          end
        end
        S_RESULT: begin
          if (!no_winner) best_time <= TIME_W'(min_time(32'(best_time), 32'(rxn_time)));
          if (!last_round) round_idx <= round_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
